// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: INCR bursts of 1-16 beats over a dual-port word array,
// with byte strobes, rlast generation and SLVERR for beats outside the address window.
module axi4_burst_mem_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = {ADDR_WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [3:0]              awlen,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [3:0]              arlen,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BA_W   = ADDR_WIDTH + 1;  // one spare bit so a burst never wraps back into range
   localparam logic [BA_W-1:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [BA_W-1:0] BEAT_INC  = BA_W'(STRB_W);
   localparam logic [BA_W-1:0] DEPTH_EXT = BA_W'(DEPTH);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

   function automatic logic beat_ok(input logic [BA_W-1:0] a);
      logic [BA_W-1:0] rel;
      rel = a - BASE_EXT;
      beat_ok = (a >= BASE_EXT) && ((rel >> OFF_W) < DEPTH_EXT);
   endfunction

   function automatic logic [IDX_W-1:0] beat_idx(input logic [BA_W-1:0] a);
      beat_idx = IDX_W'((a - BASE_EXT) >> OFF_W);
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   wstate_t         wstate_q, wstate_d;
   logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [BA_W-1:0] waddr_q, waddr_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic            werr_q, werr_d;
   logic            wbeat_s, wok_s;

   rstate_t               rstate_q, rstate_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [BA_W-1:0]       raddr_q, raddr_d;
   logic [3:0]            rcnt_q, rcnt_d;
   logic [BA_W-1:0]       rd_addr_s;
   logic                  rd_ok_s;
   logic [DATA_WIDTH-1:0] rd_word_s;

   assign wbeat_s = (wstate_q == W_DATA) && wvalid && wready_q;
   assign wok_s   = beat_ok(waddr_q);

   // Write channel next-state: address accept, beat counting, error accumulation, response
   always_comb begin
      wstate_d  = wstate_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      waddr_d   = waddr_q;
      wcnt_d    = wcnt_q;
      werr_d    = werr_q;
      case (wstate_q)
         W_IDLE: begin
            if (awvalid && awready_q) begin
               waddr_d   = {1'b0, awaddr};
               wcnt_d    = awlen;
               werr_d    = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               wstate_d  = W_DATA;
            end else begin
               awready_d = 1'b1;
            end
         end
         W_DATA: begin
            if (wbeat_s) begin
               werr_d  = werr_q | ~wok_s;
               waddr_d = waddr_q + BEAT_INC;
               if (wcnt_q == 4'd0) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = (werr_q || !wok_s) ? 2'b10 : 2'b00;
                  wstate_d = W_RESP;
               end else begin
                  wcnt_d = wcnt_q - 4'd1;
               end
            end else begin
               wready_d = 1'b1;
            end
         end
         W_RESP: begin
            if (bvalid_q && bready) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               awready_d = 1'b1;
               wstate_d  = W_IDLE;
            end else begin
               bvalid_d = 1'b1;
            end
         end
         default: begin
            wstate_d  = W_IDLE;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b0;
            bresp_d   = 2'b00;
         end
      endcase
   end

   // Address and data of the beat that the read channel will present next
   always_comb begin
      if (rstate_q == R_IDLE) begin
         rd_addr_s = {1'b0, araddr};
      end else begin
         rd_addr_s = raddr_q + BEAT_INC;
      end
      rd_ok_s = beat_ok(rd_addr_s);
      if (rd_ok_s) begin
         rd_word_s = mem[beat_idx(rd_addr_s)];
      end else begin
         rd_word_s = {DATA_WIDTH{1'b0}};
      end
   end

   // Read channel next-state: address accept, beat presentation held under backpressure
   always_comb begin
      rstate_d  = rstate_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      raddr_d   = raddr_q;
      rcnt_d    = rcnt_q;
      case (rstate_q)
         R_IDLE: begin
            if (arvalid && arready_q) begin
               raddr_d   = rd_addr_s;
               rcnt_d    = arlen;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = rd_word_s;
               rresp_d   = rd_ok_s ? 2'b00 : 2'b10;
               rlast_d   = (arlen == 4'd0);
               rstate_d  = R_DATA;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_DATA: begin
            if (rvalid_q && rready) begin
               if (rcnt_q == 4'd0) begin
                  rvalid_d  = 1'b0;
                  rdata_d   = {DATA_WIDTH{1'b0}};
                  rresp_d   = 2'b00;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  rstate_d  = R_IDLE;
               end else begin
                  raddr_d = rd_addr_s;
                  rcnt_d  = rcnt_q - 4'd1;
                  rdata_d = rd_word_s;
                  rresp_d = rd_ok_s ? 2'b00 : 2'b10;
                  rlast_d = (rcnt_q == 4'd1);
               end
            end else begin
               rvalid_d = 1'b1;
            end
         end
         default: begin
            rstate_d  = R_IDLE;
            arready_d = 1'b0;
            rvalid_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs for both channels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         waddr_q   <= {BA_W{1'b0}};
         wcnt_q    <= 4'd0;
         werr_q    <= 1'b0;
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= {DATA_WIDTH{1'b0}};
         rresp_q   <= 2'b00;
         rlast_q   <= 1'b0;
         raddr_q   <= {BA_W{1'b0}};
         rcnt_q    <= 4'd0;
      end else begin
         wstate_q  <= wstate_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         waddr_q   <= waddr_d;
         wcnt_q    <= wcnt_d;
         werr_q    <= werr_d;
         rstate_q  <= rstate_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         raddr_q   <= raddr_d;
         rcnt_q    <= rcnt_d;
      end
   end

   // Array write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wbeat_s && wok_s) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
               mem[beat_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end else begin
               mem[beat_idx(waddr_q)][8*b +: 8] <= mem[beat_idx(waddr_q)][8*b +: 8];
            end
         end
      end else begin
         mem[beat_idx(waddr_q)] <= mem[beat_idx(waddr_q)];
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rlast   = rlast_q;
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Self-checking bench for axi4_burst_mem_slave: directed scenarios plus randomized
// bursts, checked against a word-array reference model of the address window.
module tb_axi4_burst_mem_slave;
   localparam int     DEPTH  = 256;
   localparam longint BASE_L = 0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        awvalid = 1'b0, awready;
   logic [31:0] awaddr = 32'h0;
   logic [3:0]  awlen = 4'h0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic        bvalid, bready = 1'b0;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0, arready;
   logic [31:0] araddr = 32'h0;
   logic [3:0]  arlen = 4'h0;
   logic        rvalid, rready = 1'b0, rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wr_data [16];
   logic [3:0]  wr_strb [16];

   axi4_burst_mem_slave dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: a beat is stored iff its byte address lies in the window [BASE, BASE + 4*DEPTH)
   function automatic bit m_in(input logic [31:0] a, input int i);
      longint la;
      la = longint'(a);
      if (la < BASE_L) return 1'b0;
      return ((la - BASE_L) / 4 + i) < DEPTH;
   endfunction

   function automatic int m_idx(input logic [31:0] a, input int i);
      return int'((longint'(a) - BASE_L) / 4 + i);
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input string tag);
      int n;
      logic [1:0] exp_resp;
      exp_resp = 2'b00;
      awvalid = 1'b1; awaddr = addr; awlen = len;
      n = 0;
      while (awready !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL %s aw_timeout: awready never rose", tag); end
      tick();
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1; wdata = wr_data[i]; wstrb = wr_strb[i];
         n = 0;
         while (wready !== 1'b1 && n < 50) begin tick(); n++; end
         tick();
         if (m_in(addr, i)) begin
            for (int b = 0; b < 4; b++)
               if (wr_strb[i][b]) ref_mem[m_idx(addr, i)][8*b +: 8] = wr_data[i][8*b +: 8];
         end else begin
            exp_resp = 2'b10;
         end
      end
      wvalid = 1'b0;
      bready = 1'b1;
      n = 0;
      while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (bvalid !== 1'b1 || bresp !== exp_resp) begin
         errors++;
         $display("FAIL %s bresp: got bvalid=%b bresp=%b, expected bvalid=1 bresp=%b", tag, bvalid, bresp, exp_resp);
      end
      tick();
      bready = 1'b0;
   endtask

   // mode 0: rready always high, 1: pattern 1,0,0,1, 2: random
   task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input int mode, input string tag);
      int n, got, cyc;
      bit stalled;
      logic [34:0] held, obs, expv;
      arvalid = 1'b1; araddr = addr; arlen = len; rready = 1'b0;
      n = 0;
      while (arready !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (n >= 50 || rvalid !== 1'b0) begin
         errors++; $display("FAIL %s ar_wait: arready=%b rvalid=%b, expected 1 and 0", tag, arready, rvalid);
      end
      tick();
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL %s latency: rvalid=%b one cycle after ar, expected 1", tag, rvalid); end
      got = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (got <= int'(len) && cyc < 300) begin
         case (mode)
            0: rready = 1'b1;
            1: rready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: rready = 1'($urandom_range(0, 1));
         endcase
         obs = {rdata, rresp, rlast};
         if (stalled) begin
            checks++;
            if (obs !== held) begin errors++; $display("FAIL %s stall_hold: got %h, expected %h", tag, obs, held); end
         end
         checks++;
         if (rvalid !== 1'b1) begin
            errors++; $display("FAIL %s rvalid_gap: rvalid=%b at beat %0d, expected 1", tag, rvalid, got);
            stalled = 1'b0;
         end else if (rready) begin
            expv = {m_in(addr, got) ? ref_mem[m_idx(addr, got)] : 32'h0,
                    m_in(addr, got) ? 2'b00 : 2'b10, (got == int'(len)) ? 1'b1 : 1'b0};
            checks++;
            if (obs !== expv) begin
               errors++; $display("FAIL %s beat%0d: got data/resp/last %h, expected %h", tag, got, obs, expv);
            end
            got++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = obs;
         end
         tick();
         cyc++;
      end
      rready = 1'b0;
      checks++;
      if (got != int'(len) + 1 || rvalid !== 1'b0 || arready !== 1'b1) begin
         errors++;
         $display("FAIL %s burst_end: beats=%0d rvalid=%b arready=%b, expected %0d,0,1", tag, got, rvalid, arready, int'(len) + 1);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast} !== 41'h0) begin
         errors++; $display("FAIL reset_outputs: some output nonzero during reset");
      end
      tick(); tick();
      rst_n = 1'b1;
      checks++;
      if (awready !== 1'b0 || arready !== 1'b0) begin
         errors++; $display("FAIL reset_release: awready=%b arready=%b before first edge, expected 0", awready, arready);
      end
      tick();
      checks++;
      if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
         errors++; $display("FAIL reset_ready: got %b, expected 11000", {awready, arready, wready, bvalid, rvalid});
      end
   endtask

   task automatic test_fill();
      for (int k = 0; k < DEPTH / 16; k++) begin
         for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
         do_write(32'(k * 64), 4'hF, "fill");
      end
   endtask

   task automatic test_single();
      wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
      do_write(32'h10, 4'h0, "single_wr");
      do_read(32'h10, 4'h0, 0, "single_rd");
   endtask

   task automatic test_burst_strobe();
      wr_data[0] = 32'hAAAAAAAA; wr_strb[0] = 4'hF;
      do_write(32'h48, 4'h0, "prestore");
      wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
      wr_data[2] = 32'h33333333; wr_data[3] = 32'h44444444;
      wr_strb[0] = 4'hF; wr_strb[1] = 4'hF; wr_strb[2] = 4'h3; wr_strb[3] = 4'hF;
      do_write(32'h40, 4'h3, "strobe_wr");
      do_read(32'h40, 4'h3, 0, "strobe_rd");
   endtask

   task automatic test_backpressure();
      do_read(32'hA0, 4'h7, 1, "backpressure");
   endtask

   task automatic test_boundary();
      for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      do_write(32'h3F8, 4'h3, "boundary_wr");
      do_read(32'h3F8, 4'h3, 0, "boundary_rd");
   endtask

   task automatic test_concurrent();
      int n;
      logic [31:0] old_v, new_v;
      for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
      fork
         do_write(32'h100, 4'h7, "conc_wr");
         do_read(32'h200, 4'h7, 2, "conc_rd");
      join
      do_read(32'h100, 4'h7, 0, "conc_check");
      old_v = ref_mem[32'h300 / 4];
      new_v = $urandom;
      awvalid = 1'b1; awaddr = 32'h300; awlen = 4'h0;
      n = 0;
      while (awready !== 1'b1 && n < 50) begin tick(); n++; end
      tick();
      awvalid = 1'b0;
      wvalid = 1'b1; wdata = new_v; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h300; arlen = 4'h0;
      checks++;
      if (wready !== 1'b1 || arready !== 1'b1) begin
         errors++; $display("FAIL same_cycle_setup: wready=%b arready=%b, expected 1 1", wready, arready);
      end
      tick();
      wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== old_v) begin
         errors++; $display("FAIL same_cycle_read: rvalid=%b rdata=%h, expected 1 %h", rvalid, rdata, old_v);
      end
      ref_mem[32'h300 / 4] = new_v;
      rready = 1'b1; tick(); rready = 1'b0;
      bready = 1'b1;
      n = 0;
      while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         errors++; $display("FAIL same_cycle_bresp: bvalid=%b bresp=%b, expected 1 00", bvalid, bresp);
      end
      tick(); bready = 1'b0;
      do_read(32'h300, 4'h0, 0, "same_cycle_after");
   endtask

   task automatic test_mid_reset();
      int n;
      awvalid = 1'b1; awaddr = 32'h80; awlen = 4'h3;
      n = 0;
      while (awready !== 1'b1 && n < 50) begin tick(); n++; end
      tick();
      awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF;
         checks++;
         if (wready !== 1'b1) begin errors++; $display("FAIL midrst_wready: beat %0d wready=%b, expected 1", i, wready); end
         tick();
         ref_mem[32'h80 / 4 + i] = wdata;
      end
      wdata = $urandom;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast} !== 41'h0) begin
         errors++; $display("FAIL midrst_outputs: some output nonzero during reset");
      end
      wvalid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin
         errors++; $display("FAIL midrst_release: awready=%b arready=%b wready=%b, expected 1 1 0", awready, arready, wready);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bvalid !== 1'b0) begin errors++; $display("FAIL midrst_no_bvalid: bvalid=%b, expected 0", bvalid); end
         tick();
      end
      do_read(32'h80, 4'h3, 0, "midrst_rd");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [3:0]  l;
      for (int it = 0; it < 16; it++) begin
         a = 32'($urandom_range(0, 32'h43F));
         l = 4'($urandom_range(0, 15));
         for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
         do_write(a, l, "rand_wr");
         a = 32'($urandom_range(0, 32'h43F));
         l = 4'($urandom_range(0, 15));
         do_read(a, l, 2, "rand_rd");
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_single();
      test_burst_strobe();
      test_backpressure();
      test_boundary();
      test_concurrent();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
